// File: rtl/dab_arb_if.sv
// Bus bundle between the four requesters, the dab_arb arbiter and the shared target.
// The arbiter uses the slave view; the requesters and target together use the master view.
interface dab_arb_if #(
  parameter int DWIDTH = 64
);
  logic [3:0]          m_rd;
  logic [3:0]          m_wr;
  logic [127:0]        m_addr;
  logic [4*DWIDTH-1:0] m_datain;
  logic [15:0]         m_sel;
  logic [15:0]         m_selh;
  logic [DWIDTH-1:0]   m_dataout;
  logic [3:0]          m_ready;
  logic                s_rd;
  logic                s_wr;
  logic [31:0]         s_addr;
  logic [DWIDTH-1:0]   s_datain;
  logic [3:0]          s_sel;
  logic [3:0]          s_selh;
  logic [DWIDTH-1:0]   s_dataout;
  logic                s_ready;
  logic [3:0]          ovf_err;
  logic                to_err;

  modport slave (
    input  m_rd, m_wr, m_addr, m_datain, m_sel, m_selh, s_dataout, s_ready,
    output m_dataout, m_ready, s_rd, s_wr, s_addr, s_datain, s_sel, s_selh, ovf_err, to_err
  );

  modport master (
    output m_rd, m_wr, m_addr, m_datain, m_sel, m_selh, s_dataout, s_ready,
    input  m_dataout, m_ready, s_rd, s_wr, s_addr, s_datain, s_sel, s_selh, ovf_err, to_err
  );
endinterface

// File: rtl/dab_arb.sv
// Four-port round-robin arbiter in front of a single shared target: one outstanding
// request per port, one target command at a time, optional target timeout.
module dab_arb #(
  parameter int DWIDTH  = 64,
  parameter int TIMEOUT = 255
) (
  input logic      HCLK,
  input logic      HRESETn,
  dab_arb_if.slave bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  logic [3:0]        pend_vld;
  logic [3:0]        pend_wr;
  logic [31:0]       pend_addr [4];
  logic [DWIDTH-1:0] pend_data [4];
  logic [3:0]        pend_sel  [4];
  logic [3:0]        pend_selh [4];
  logic [1:0]        rr_ptr;
  logic [1:0]        grant;
  logic [1:0]        next_grant;
  logic [1:0]        scan_idx;
  logic              any_pend;
  logic [31:0]       wait_cnt;
  logic [3:0]        req;
  logic [3:0]        busy;
  logic [3:0]        accept;
  logic [3:0]        drop;
  logic              timeout_hit;
  logic              done;

  // A port that already holds a request (granted or not) cannot take another.
  always_comb begin
    req  = bus.m_rd | bus.m_wr;
    busy = pend_vld;
    if (state == WAIT) busy[grant] = 1'b1;
    accept = req & ~busy;
    drop   = req & busy;
  end

  // Scan from the farthest offset inward so the nearest pending port after rr_ptr wins.
  always_comb begin
    next_grant = rr_ptr;
    any_pend   = 1'b0;
    scan_idx   = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = rr_ptr + 2'(k);
      if (pend_vld[scan_idx]) begin
        next_grant = scan_idx;
        any_pend   = 1'b1;
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == 32'(TIMEOUT - 1)) && !bus.s_ready;
  assign done        = (state == WAIT) && (bus.s_ready || timeout_hit);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_vld <= '0;
      pend_wr  <= '0;
      for (int i = 0; i < 4; i++) begin
        pend_addr[i] <= '0;
        pend_data[i] <= '0;
        pend_sel[i]  <= '0;
        pend_selh[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept[i]) begin
          pend_vld[i]  <= 1'b1;
          pend_wr[i]   <= bus.m_wr[i];
          pend_addr[i] <= bus.m_addr[32*i +: 32];
          pend_data[i] <= bus.m_datain[DWIDTH*i +: DWIDTH];
          pend_sel[i]  <= bus.m_sel[4*i +: 4];
          pend_selh[i] <= bus.m_selh[4*i +: 4];
        end else if (done && grant == 2'(i)) begin
          pend_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      wait_cnt      <= '0;
      bus.m_ready   <= '0;
      bus.m_dataout <= '0;
      bus.s_rd      <= 1'b0;
      bus.s_wr      <= 1'b0;
      bus.s_addr    <= '0;
      bus.s_datain  <= '0;
      bus.s_sel     <= '0;
      bus.s_selh    <= '0;
      bus.ovf_err   <= '0;
      bus.to_err    <= 1'b0;
    end else begin
      bus.m_ready <= '0;
      bus.s_rd    <= 1'b0;
      bus.s_wr    <= 1'b0;
      bus.to_err  <= 1'b0;
      bus.ovf_err <= drop;
      case (state)
        IDLE: begin
          if (any_pend) begin
            grant        <= next_grant;
            bus.s_addr   <= pend_addr[next_grant];
            bus.s_datain <= pend_data[next_grant];
            bus.s_sel    <= pend_sel[next_grant];
            bus.s_selh   <= pend_selh[next_grant];
            bus.s_wr     <= pend_wr[next_grant];
            bus.s_rd     <= !pend_wr[next_grant];
            wait_cnt     <= '0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          // A timed-out transfer completes like a normal one but returns zero data.
          if (done) begin
            bus.m_ready   <= 4'b0001 << grant;
            bus.m_dataout <= (bus.s_ready && !pend_wr[grant]) ? bus.s_dataout : '0;
            bus.to_err    <= !bus.s_ready;
            rr_ptr        <= grant + 2'd1;
            state         <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dab_arb.sv
// Scoreboard bench for dab_arb: a transaction-level model predicts commands, completions
// and overflow pulses; a negedge monitor compares whatever the DUT presents against it.
module tb_dab_arb;

  localparam int DW = 64;
  localparam int TO = 4;

  typedef struct {
    int            cyc;
    logic          is_wr;
    logic [31:0]   addr;
    logic [DW-1:0] data;
    logic [3:0]    sel;
    logic [3:0]    selh;
  } cmd_t;

  typedef struct {
    int            cyc;
    logic [3:0]    port;
    logic [DW-1:0] data;
    logic          to;
  } cmpl_t;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } ovf_t;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;

  dab_arb_if #(.DWIDTH(DW)) bus ();

  dab_arb #(.DWIDTH(DW), .TIMEOUT(TO)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int    total = 0;
  int    bad   = 0;
  cmd_t  cmd_q  [$];
  cmpl_t cmpl_q [$];
  ovf_t  ovf_q  [$];

  // Reference model: which ports hold a request, the rotation pointer, and the
  // transfer the shared target is currently serving.
  logic [3:0]    mdl_pend = '0;
  cmd_t          mdl_req [4];
  int            mdl_rr   = 0;
  bit            mdl_busy = 0;
  int            mdl_gnt  = 0;
  int            mdl_wait = 0;
  int            mdl_lat  = 0;
  int            cfg_lat  = -1;
  bit            force_addr_en  = 0;
  logic [31:0]   force_addr     = '0;
  bit            force_rdata_en = 0;
  logic [DW-1:0] force_rdata    = '0;
  bit            end_req  = 0;
  bit            end_done = 0;

  cmd_t          ce;
  cmpl_t         pe;
  ovf_t          oe;
  logic [31:0]   hold_addr = '0;
  logic [DW-1:0] hold_dout = '0;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model then predicts what the next edge must produce.
  task automatic apply_stimulus(input logic [3:0] rd, input logic [3:0] wr);
    logic [3:0]    pulse;
    logic [3:0]    pend_before;
    logic [3:0]    accepted;
    logic [3:0]    ovf_vec;
    logic          s_rdy;
    logic [DW-1:0] rdata;
    cmd_t          rq;
    int            g;
    bit            found;
    @(posedge HCLK);
    #1;
    pulse = rd | wr;
    for (int i = 0; i < 4; i++) begin
      bus.m_addr[32*i +: 32]   = force_addr_en ? force_addr : $urandom;
      bus.m_datain[DW*i +: DW] = {$urandom, $urandom};
      bus.m_sel[4*i +: 4]      = 4'($urandom);
      bus.m_selh[4*i +: 4]     = 4'($urandom);
    end
    rdata = force_rdata_en ? force_rdata : {$urandom, $urandom};
    s_rdy = mdl_busy && (mdl_wait == mdl_lat);
    bus.m_rd      = rd;
    bus.m_wr      = wr;
    bus.s_dataout = rdata;
    bus.s_ready   = s_rdy;

    pend_before = mdl_pend;
    accepted    = '0;
    ovf_vec     = '0;
    for (int i = 0; i < 4; i++) begin
      if (pulse[i]) begin
        if (mdl_pend[i]) begin
          ovf_vec[i] = 1'b1;
        end else begin
          accepted[i]     = 1'b1;
          mdl_req[i].cyc   = 0;
          mdl_req[i].is_wr = wr[i];
          mdl_req[i].addr  = bus.m_addr[32*i +: 32];
          mdl_req[i].data  = bus.m_datain[DW*i +: DW];
          mdl_req[i].sel   = bus.m_sel[4*i +: 4];
          mdl_req[i].selh  = bus.m_selh[4*i +: 4];
        end
      end
    end
    if (ovf_vec != 4'b0000) ovf_q.push_back('{cyc: cyc + 1, vec: ovf_vec});

    if (mdl_busy) begin
      if (s_rdy || (TO != 0 && mdl_wait == TO - 1)) begin
        cmpl_q.push_back('{cyc:  cyc + 1,
                           port: 4'(1 << mdl_gnt),
                           data: (s_rdy && !mdl_req[mdl_gnt].is_wr) ? rdata : DW'(0),
                           to:   !s_rdy});
        pend_before[mdl_gnt] = 1'b0;
        mdl_rr   = (mdl_gnt + 1) % 4;
        mdl_busy = 0;
      end else begin
        mdl_wait++;
      end
    end else if (pend_before != 4'b0000) begin
      found = 0;
      g     = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && pend_before[(mdl_rr + k) % 4]) begin
          g     = (mdl_rr + k) % 4;
          found = 1;
        end
      end
      rq     = mdl_req[g];
      rq.cyc = cyc + 1;
      cmd_q.push_back(rq);
      mdl_busy = 1;
      mdl_gnt  = g;
      mdl_wait = 0;
      mdl_lat  = (cfg_lat >= 0) ? cfg_lat :
                 (($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3)));
    end
    mdl_pend = pend_before | accepted;
  endtask

  task automatic apply_reset();
    @(posedge HCLK);
    #2;
    HRESETn     = 1'b0;
    bus.m_rd    = '0;
    bus.m_wr    = '0;
    bus.s_ready = 1'b0;
    mdl_pend = '0;
    mdl_rr   = 0;
    mdl_busy = 0;
    mdl_gnt  = 0;
    mdl_wait = 0;
    mdl_lat  = 0;
    repeat (2) @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(4'b0000, 4'b0000);
  endtask

  // Monitor: pops an expectation whenever the DUT shows an output, or when one is overdue.
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      cmd_q.delete();
      cmpl_q.delete();
      ovf_q.delete();
      hold_addr = '0;
      hold_dout = '0;
      check_output("rst_m_ready",   128'(bus.m_ready),   128'(0));
      check_output("rst_m_dataout", 128'(bus.m_dataout), 128'(0));
      check_output("rst_s_cmd",     128'({bus.s_rd, bus.s_wr}), 128'(0));
      check_output("rst_s_fields",  128'({bus.s_addr, bus.s_sel, bus.s_selh}), 128'(0));
      check_output("rst_s_datain",  128'(bus.s_datain),  128'(0));
      check_output("rst_errs",      128'({bus.ovf_err, bus.to_err}), 128'(0));
    end else begin
      if (bus.s_rd || bus.s_wr) begin
        if (cmd_q.size() == 0) begin
          check_output("cmd_spurious", 128'({bus.s_rd, bus.s_wr}), 128'(0));
        end else begin
          ce = cmd_q.pop_front();
          check_output("cmd_cycle",  128'(cyc), 128'(ce.cyc));
          check_output("cmd_type",   128'({bus.s_rd, bus.s_wr}), 128'({!ce.is_wr, ce.is_wr}));
          check_output("cmd_addr",   128'(bus.s_addr),   128'(ce.addr));
          check_output("cmd_data",   128'(bus.s_datain), 128'(ce.data));
          check_output("cmd_sel",    128'({bus.s_sel, bus.s_selh}), 128'({ce.sel, ce.selh}));
          hold_addr = ce.addr;
        end
      end else if (cmd_q.size() != 0 && cmd_q[0].cyc <= cyc) begin
        ce = cmd_q.pop_front();
        check_output("cmd_missing", 128'({bus.s_rd, bus.s_wr}), 128'({!ce.is_wr, ce.is_wr}));
      end
      check_output("s_addr_hold", 128'(bus.s_addr), 128'(hold_addr));

      if (bus.m_ready != 4'b0000) begin
        if (cmpl_q.size() == 0) begin
          check_output("ready_spurious", 128'(bus.m_ready), 128'(0));
        end else begin
          pe = cmpl_q.pop_front();
          check_output("cmpl_cycle", 128'(cyc), 128'(pe.cyc));
          check_output("cmpl_port",  128'(bus.m_ready),   128'(pe.port));
          check_output("cmpl_data",  128'(bus.m_dataout), 128'(pe.data));
          check_output("cmpl_to",    128'(bus.to_err),    128'(pe.to));
          hold_dout = pe.data;
        end
      end else if (cmpl_q.size() != 0 && cmpl_q[0].cyc <= cyc) begin
        pe = cmpl_q.pop_front();
        check_output("cmpl_missing", 128'(bus.m_ready), 128'(pe.port));
      end else if (bus.to_err) begin
        check_output("to_spurious", 128'(bus.to_err), 128'(0));
      end
      check_output("m_dataout_hold", 128'(bus.m_dataout), 128'(hold_dout));

      if (bus.ovf_err != 4'b0000) begin
        if (ovf_q.size() == 0) begin
          check_output("ovf_spurious", 128'(bus.ovf_err), 128'(0));
        end else begin
          oe = ovf_q.pop_front();
          check_output("ovf_cycle", 128'(cyc), 128'(oe.cyc));
          check_output("ovf_vec",   128'(bus.ovf_err), 128'(oe.vec));
        end
      end else if (ovf_q.size() != 0 && ovf_q[0].cyc <= cyc) begin
        oe = ovf_q.pop_front();
        check_output("ovf_missing", 128'(bus.ovf_err), 128'(oe.vec));
      end

      if (end_req && !end_done) begin
        check_output("cmd_q_left",  128'(cmd_q.size()),  128'(0));
        check_output("cmpl_q_left", 128'(cmpl_q.size()), 128'(0));
        check_output("ovf_q_left",  128'(ovf_q.size()),  128'(0));
        end_done = 1;
      end
    end
  end

  initial begin
    bus.m_rd      = '0;
    bus.m_wr      = '0;
    bus.m_addr    = '0;
    bus.m_datain  = '0;
    bus.m_sel     = '0;
    bus.m_selh    = '0;
    bus.s_dataout = '0;
    bus.s_ready   = 1'b0;
    apply_reset();

    $display("[TB] single read on port 1");
    force_addr_en  = 1;
    force_addr     = 32'h0000_0100;
    force_rdata_en = 1;
    force_rdata    = DW'(64'hA5);
    cfg_lat        = 1;
    apply_stimulus(4'b0010, 4'b0000);
    idle(6);
    force_addr_en  = 0;
    force_rdata_en = 0;

    $display("[TB] four simultaneous writes");
    apply_reset();
    cfg_lat = 0;
    apply_stimulus(4'b0000, 4'b1111);
    idle(12);

    $display("[TB] rotation after port 2");
    apply_stimulus(4'b0000, 4'b0100);
    idle(4);
    apply_stimulus(4'b0000, 4'b1001);
    idle(10);

    $display("[TB] overflow while pending");
    cfg_lat = 2;
    apply_stimulus(4'b0001, 4'b0001);
    apply_stimulus(4'b0000, 4'b0001);
    idle(8);

    $display("[TB] target timeout");
    cfg_lat = 50;
    apply_stimulus(4'b0100, 4'b0000);
    idle(10);

    $display("[TB] reset during wait");
    apply_stimulus(4'b0000, 4'b1000);
    idle(3);
    apply_reset();
    idle(8);

    $display("[TB] random traffic");
    cfg_lat = -1;
    for (int n = 0; n < 1500; n++) begin
      apply_stimulus(4'($urandom) & 4'($urandom) & 4'($urandom),
                     4'($urandom) & 4'($urandom) & 4'($urandom));
    end

    cfg_lat = 1;
    for (int n = 0; n < 100 && (mdl_busy || mdl_pend != 4'b0000); n++) idle(1);
    idle(3);
    end_req = 1;
    repeat (3) @(posedge HCLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
